// File: rtl/pkt_encap.sv
// Packet encapsulator: frames a block of memory words into headered packets for router input port 0.
// Optional per-packet XOR trailer word is compiled in with PKT_ENCAP_CRC_EN.
module pkt_encap #(
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH        = 10,
    parameter int NUMBER_PACKET     = 19,
    parameter int PAYLOAD_WORDS     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_encap_pkt,
    input  logic [ADDR_WIDTH-1:0]        src_addr,
    input  logic [ADDR_WIDTH-1:0]        router_dst_addr_send,
    input  logic [8:0]                   header_pkt_send,
    output logic                         mem_rd_en,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [AURORA_DATA_WIDTH-1:0] mem_rdata,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [AURORA_DATA_WIDTH-1:0] fifo_wdata,
    output logic                         busy,
    output logic                         encap_done
);

    localparam int PN_W = (NUMBER_PACKET > 1) ? $clog2(NUMBER_PACKET) : 1;
    localparam int WC_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam logic [PN_W-1:0] LAST_PKT  = PN_W'(NUMBER_PACKET - 1);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(PAYLOAD_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RD,
        S_WAIT,
        S_PAY,
`ifdef PKT_ENCAP_CRC_EN
        S_TRL,
`endif
        S_DONE
    } state_t;

    state_t                         state_q, state_nx;
    logic [ADDR_WIDTH-1:0]          src_q, dst_q, rd_idx;
    logic [1:0]                     ttl_q, srt_q;
    logic [PN_W-1:0]                pkt_cnt;
    logic [WC_W-1:0]                word_cnt;
    logic [AURORA_DATA_WIDTH-1:0]   hold_q;
    logic [AURORA_DATA_WIDTH-1:0]   hdr_word;
    logic                           last_pkt, last_word, pkt_end;
    logic                           unused_hdr_bits;

    assign unused_hdr_bits = ^header_pkt_send[6:2];
    assign last_pkt  = (pkt_cnt == LAST_PKT);
    assign last_word = (word_cnt == LAST_WORD);

    always_comb begin
        hdr_word = '0;
        hdr_word[9 +: ADDR_WIDTH] = dst_q;
        hdr_word[8:7] = ttl_q;
        hdr_word[6:2] = 5'(pkt_cnt);
        hdr_word[1:0] = srt_q;
    end

`ifdef PKT_ENCAP_CRC_EN
    logic [AURORA_DATA_WIDTH-1:0] crc_q;

    // Accumulator restarts from each accepted header, then folds in every accepted payload word.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else if (fifo_wr_en) begin
            if (state_q == S_HDR) begin
                crc_q <= hdr_word;
            end else if (state_q == S_PAY) begin
                crc_q <= crc_q ^ hold_q;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            ttl_q    <= '0;
            srt_q    <= '0;
            pkt_cnt  <= '0;
            word_cnt <= '0;
            rd_idx   <= '0;
            hold_q   <= '0;
        end else begin
            state_q <= state_nx;
            case (state_q)
                S_IDLE: begin
                    if (start_encap_pkt) begin
                        src_q    <= src_addr;
                        dst_q    <= router_dst_addr_send;
                        ttl_q    <= header_pkt_send[8:7];
                        srt_q    <= header_pkt_send[1:0];
                        pkt_cnt  <= '0;
                        word_cnt <= '0;
                        rd_idx   <= '0;
                    end
                end
                S_RD:   rd_idx <= rd_idx + 1'b1;
                S_WAIT: hold_q <= mem_rdata;
                S_PAY: begin
                    if (fifo_wr_en && !last_word) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (pkt_end && !last_pkt) begin
                pkt_cnt  <= pkt_cnt + 1'b1;
                word_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nx   = state_q;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        fifo_wr_en = 1'b0;
        fifo_wdata = '0;
        busy       = 1'b1;
        encap_done = 1'b0;
        pkt_end    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start_encap_pkt) begin
                    state_nx = S_HDR;
                end
            end
            S_HDR: begin
                fifo_wdata = hdr_word;
                fifo_wr_en = !fifo_full;
                if (!fifo_full) begin
                    state_nx = S_RD;
                end
            end
            S_RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = src_q + rd_idx;
                state_nx  = S_WAIT;
            end
            S_WAIT: state_nx = S_PAY;
            S_PAY: begin
                fifo_wdata = hold_q;
                fifo_wr_en = !fifo_full;
                if (!fifo_full) begin
                    if (!last_word) begin
                        state_nx = S_RD;
                    end else begin
`ifdef PKT_ENCAP_CRC_EN
                        state_nx = S_TRL;
`else
                        pkt_end = 1'b1;
`endif
                    end
                end
            end
`ifdef PKT_ENCAP_CRC_EN
            S_TRL: begin
                fifo_wdata = crc_q;
                fifo_wr_en = !fifo_full;
                if (!fifo_full) begin
                    pkt_end = 1'b1;
                end
            end
`endif
            S_DONE: begin
                busy       = 1'b0;
                encap_done = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (pkt_end) begin
            state_nx = last_pkt ? S_DONE : S_HDR;
        end
    end

endmodule
